// File: rtl/regfile_trace_buffer.sv
// regfile_trace_buffer: shadows every register-file write and traces
// qualifying writes {index, value, timestamp} into a first-word-fall-through FIFO.
//
// Ports:
//   clock, reset        - sole clock; asynchronous active-high reset
//   rf_we/rf_waddr/
//   rf_wdata            - observed register-file write port
//   trace_enable        - capture qualifying writes into the FIFO
//   clear               - synchronous flush of FIFO, overflow and drop_count
//   rd_ready/rd_valid/
//   rd_addr/rd_data/
//   rd_ts               - FWFT read side (head entry, no read latency)
//   count               - occupied entries
//   overflow/drop_count - sticky drop flag and saturating drop counter
//   sh_addr/sh_data     - combinational shadow register query
//
// Optional feature: define TRACE_TIMESTAMP_EN to build the free-running
// timestamp counter and per-entry timestamp storage; otherwise rd_ts is 0.

module regfile_trace_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 16,
   parameter int TS_WIDTH   = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    rf_we,
   input  logic [ADDR_WIDTH-1:0]   rf_waddr,
   input  logic [DATA_WIDTH-1:0]   rf_wdata,
   input  logic                    trace_enable,
   input  logic                    clear,
   input  logic                    rd_ready,
   output logic                    rd_valid,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic [TS_WIDTH-1:0]     rd_ts,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic [7:0]              drop_count,
   input  logic [ADDR_WIDTH-1:0]   sh_addr,
   output logic [DATA_WIDTH-1:0]   sh_data
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic                  qual;
   logic                  want;
   logic                  full;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic [PW-1:0]         wptr;
   logic [PW-1:0]         rptr;

   logic [DATA_WIDTH-1:0] shadow  [NREG];
   logic [ADDR_WIDTH-1:0] mem_adr [DEPTH];
   logic [DATA_WIDTH-1:0] mem_dat [DEPTH];

   // Index 0 is hardwired zero in the register file, so it is never traced.
   assign qual     = rf_we && (rf_waddr != '0);
   assign want     = qual && trace_enable && !clear;
   assign full     = (count == CW'(DEPTH));
   assign rd_valid = (count != '0);
   assign pop      = rd_valid && rd_ready && !clear;
   // A same-cycle pop frees a slot, so a full FIFO still accepts the push.
   assign push     = want && (!full || pop);
   assign drop     = want && full && !pop;

   // Shadow copy of the register file; not affected by trace_enable/clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            shadow[i] <= '0;
         end
      end else if (qual) begin
         shadow[rf_waddr] <= rf_wdata;
      end
   end

   always_comb begin
      sh_data = '0;
      if (sh_addr != '0) begin
         sh_data = shadow[sh_addr];
      end
   end

   // Pointers, occupancy and drop bookkeeping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (clear) begin
         wptr       <= '0;
         rptr       <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
         end
      end
   end

   // Storage needs no reset: the pointers alone decide what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_adr[wptr] <= rf_waddr;
         mem_dat[wptr] <= rf_wdata;
      end
   end

   assign rd_addr = mem_adr[rptr];
   assign rd_data = mem_dat[rptr];

`ifdef TRACE_TIMESTAMP_EN
   logic [TS_WIDTH-1:0] ts;
   logic [TS_WIDTH-1:0] mem_ts [DEPTH];

   // Free-running; the stored value is the count before this edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_WIDTH'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_ts[wptr] <= ts;
      end
   end

   assign rd_ts = mem_ts[rptr];
`else
   assign rd_ts = '0;
`endif

endmodule
